zero_flag_pipe: RTL and testbench
=================================

# zero_flag_pipe

Parametrised, pipelined successor to the combinational 64-bit zero detector used for the CPU's flag generation. It reduces a WIDTH-bit result through a registered OR tree of configurable fan-in, producing zero and negative flags with a valid/ready handshake, stall and flush support. It also maintains an architectural N/Z flag register updated only by beats tagged `setflags`. It sits between the ALU result and the flag/branch logic in the execute/memory stages.

## Interface
- WIDTH, 64, operand width in bits; legal range 2..128.
- FANIN, 4, inputs per OR node per tree level; legal values 2, 4, 8.
- clk  input  1  clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  pipe can accept a beat this cycle.
- in_data  input  WIDTH  value to test.
- in_setflags  input  1  beat updates the flag register when it retires.
- flush  input  1  synchronous kill of all in-flight beats.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result beat.
- out_zero  output  1  in_data of this beat was all zeros.
- out_neg  output  1  in_data[WIDTH-1] of this beat.
- out_parity  output  1  XOR of all in_data bits (see Configuration).
- flag_z  output  1  architectural Z flag.
- flag_n  output  1  architectural N flag.

## Operation
- LEVELS = ceil(log_FANIN(WIDTH)). Input is zero-padded on the MSB side to FANIN^LEVELS bits.
- Tree level k ORs groups of FANIN bits from level k-1; each level output is registered. Stage 1 captures from in_data.
- Each stage carries: valid, partial OR vector, neg bit (in_data[WIDTH-1] captured at stage 1), setflags tag, and partial parity if enabled.
- Final stage holds a single OR bit `nz`. out_zero = out_valid & ~nz; out_neg = out_valid & neg; out_parity = out_valid & parity.
- Advance enable: adv = ~out_valid | out_ready. All stages shift together when adv=1 and hold when adv=0; bubbles are not collapsed.
- in_ready = adv & ~flush.
- On adv=1 without flush, stage 1 valid <= in_valid.
- Flag register: on out_valid & out_ready & tag, set flag_z <= ~nz and flag_n <= neg. Beats without the tag retire without touching the flags.
- Flush: every stage valid <= 0 next edge. An input presented during flush is discarded; flush has priority over in_valid.
  - If an output handshake completes in the same cycle as flush, that beat still retires and may update the flags.
- Reset (asynchronous, any time including mid-operation): all valids, data registers, tags, flag_z and flag_n <= 0.
  - Outputs after reset: out_valid=0, out_zero=0, out_neg=0, out_parity=0, flag_z=0, flag_n=0, in_ready=1.

## Timing
- Latency: a beat accepted at edge t presents out_valid at edge t+LEVELS-1, i.e. LEVELS register stages. WIDTH=64, FANIN=4 gives LEVELS=3.
- Throughput: one beat per cycle while out_ready=1.
- Stall: with out_ready=0 and out_valid=1, no stage changes and in_ready=0 in the same cycle (combinational path from out_ready).
- Flag registers reflect a retiring beat one edge after its handshake.
- No combinational path from in_* to out_*.

## Configuration
- `ZCHK_PARITY_EN` defined: a parallel registered XOR tree runs alongside the OR tree with identical staging, and out_parity carries the even parity of in_data.
- `ZCHK_PARITY_EN` undefined: no parity logic is built and out_parity is tied to 0. The port list is unchanged.

## Structure
- Package `zchk_pkg`:
  - constant function `zchk_levels(width, fanin)`;
  - padded-width function;
  - legal-FANIN check, enforced by an elaboration-time assertion.
- Sub-module `or_reduce_stage`: one registered tree level, parameterised on input width and FANIN, with enable and async clear. It carries valid, neg, tag and the optional parity slice. It is instantiated LEVELS times via generate.

## Test plan
- WIDTH=64, FANIN=4: issue 0x0 with setflags=1, then 0x8000_0000_0000_0000 with setflags=1, out_ready=1.
  - out_valid at cycle 3 with zero=1, neg=0; next cycle zero=0, neg=1.
  - flag_z/flag_n end at 0/1.
- Walking single 1 across all 64 bit positions -> out_zero=0 for every beat. Parity (if enabled) = 1 for every beat.
- Hold out_ready=0 for 5 cycles with 3 beats in flight -> outputs stable, in_ready=0. Release -> beats emerge in order, none lost or duplicated.
- Assert flush with 3 beats in flight and in_valid=1 -> out_valid=0 from next cycle, no flag update, the flush-cycle input is dropped.
- Deassert reset_n mid-stream with flag_z=1 -> all outputs 0 immediately, asynchronously. Operation resumes normally after release.
- WIDTH=37, FANIN=8 (LEVELS=2, padded to 64): input with only bit 36 set -> zero=0, neg=1 at latency 2.

Source files
------------

// File: rtl/zchk_pkg.sv
// zchk_pkg: sizing helpers for the pipelined zero/flag detector.
package zchk_pkg;
  function automatic int zchk_levels(input int width, input int fanin);
    int l = 0;
    int p = 1;
    while (p < width) begin
      p = p * fanin;
      l++;
    end
    return l;
  endfunction
  function automatic int zchk_pow(input int base, input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * base;
    return p;
  endfunction
  function automatic int zchk_padded(input int width, input int fanin);
    return zchk_pow(fanin, zchk_levels(width, fanin));
  endfunction
  function automatic bit zchk_fanin_ok(input int fanin);
    return fanin == 2 || fanin == 4 || fanin == 8;
  endfunction
endpackage

// File: rtl/or_reduce_stage.sv
// or_reduce_stage: one registered OR-tree level (optional XOR slice under ZCHK_PARITY_EN).
module or_reduce_stage #(
  parameter int IN_W  = 64,
  parameter int FANIN = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    flush,
  input  logic                    v_in,
  input  logic                    n_in,
  input  logic                    t_in,
  input  logic [IN_W-1:0]         d_in,
  output logic                    v_out,
  output logic                    n_out,
  output logic                    t_out,
  output logic [IN_W/FANIN-1:0]   d_out
`ifdef ZCHK_PARITY_EN
  ,input  logic [IN_W-1:0]        p_in
  ,output logic [IN_W/FANIN-1:0]  p_out
`endif
);
  localparam int OUT_W = IN_W / FANIN;
  logic [OUT_W-1:0] or_d;
  for (genvar j = 0; j < OUT_W; j++) begin : g_or
    assign or_d[j] = |d_in[j*FANIN +: FANIN];
  end
  // flush clears valid even while stalled; data only moves on enable
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v_out <= 1'b0;
      n_out <= 1'b0;
      t_out <= 1'b0;
      d_out <= '0;
    end else begin
      v_out <= flush ? 1'b0 : en ? v_in : v_out;
      if (en) begin
        n_out <= n_in;
        t_out <= t_in;
        d_out <= or_d;
      end
    end
`ifdef ZCHK_PARITY_EN
  logic [OUT_W-1:0] x_d;
  for (genvar j = 0; j < OUT_W; j++) begin : g_xor
    assign x_d[j] = ^p_in[j*FANIN +: FANIN];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) p_out <= '0;
    else if (en) p_out <= x_d;
`endif
endmodule

// File: rtl/zero_flag_pipe.sv
// zero_flag_pipe: pipelined OR-tree zero/neg detector with N/Z flag register; parity tree via ZCHK_PARITY_EN.
module zero_flag_pipe
  import zchk_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int FANIN = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_setflags,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_parity,
  output logic             flag_z,
  output logic             flag_n
);
  localparam int LEVELS = zchk_levels(WIDTH, FANIN);
  localparam int PW     = zchk_padded(WIDTH, FANIN);
  if (!zchk_fanin_ok(FANIN)) begin : g_bad_fanin
    $error("zero_flag_pipe: FANIN must be 2, 4 or 8");
  end
  if (WIDTH < 2 || WIDTH > 128) begin : g_bad_width
    $error("zero_flag_pipe: WIDTH must be 2..128");
  end
  logic adv, nz, neg, tag;
  logic [PW-1:0] pad;
  assign pad = PW'(in_data);
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv & ~flush;
  for (genvar i = 0; i < LEVELS; i++) begin : g
    localparam int IW = PW / zchk_pow(FANIN, i);
    localparam int OW = IW / FANIN;
    logic v, n, t;
    logic [OW-1:0] d;
`ifdef ZCHK_PARITY_EN
    logic [OW-1:0] p;
`endif
    if (i == 0) begin : s
      or_reduce_stage #(.IN_W(IW), .FANIN(FANIN)) u_stage (
        .clk, .reset_n, .en(adv), .flush,
        .v_in(in_valid), .n_in(in_data[WIDTH-1]), .t_in(in_setflags), .d_in(pad),
        .v_out(v), .n_out(n), .t_out(t), .d_out(d)
`ifdef ZCHK_PARITY_EN
        , .p_in(pad), .p_out(p)
`endif
      );
    end else begin : s
      or_reduce_stage #(.IN_W(IW), .FANIN(FANIN)) u_stage (
        .clk, .reset_n, .en(adv), .flush,
        .v_in(g[i-1].v), .n_in(g[i-1].n), .t_in(g[i-1].t), .d_in(g[i-1].d),
        .v_out(v), .n_out(n), .t_out(t), .d_out(d)
`ifdef ZCHK_PARITY_EN
        , .p_in(g[i-1].p), .p_out(p)
`endif
      );
    end
  end
  assign out_valid = g[LEVELS-1].v;
  assign nz        = g[LEVELS-1].d;
  assign neg       = g[LEVELS-1].n;
  assign tag       = g[LEVELS-1].t;
  assign out_zero  = out_valid & ~nz;
  assign out_neg   = out_valid & neg;
`ifdef ZCHK_PARITY_EN
  assign out_parity = out_valid & g[LEVELS-1].p;
`else
  assign out_parity = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (out_valid && out_ready && tag) begin
      flag_z <= ~nz;
      flag_n <= neg;
    end
endmodule

// File: tb/tb_zero_flag_pipe.sv
// tb_zero_flag_pipe: randomized + directed checks of zero_flag_pipe against a slot-level reference model.
module tb_zero_flag_pipe;
  localparam int L = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid, in_ready, in_setflags, flush, out_valid, out_ready;
  logic out_zero, out_neg, out_parity, flag_z, flag_n;
  logic [63:0] in_data;
  logic b_valid, b_in_ready, b_tag, b_flush, b_out_valid, b_out_ready;
  logic b_zero, b_neg, b_parity, b_fz, b_fn;
  logic [36:0] b_data;
  zero_flag_pipe #(.WIDTH(64), .FANIN(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_setflags(in_setflags), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_zero(out_zero), .out_neg(out_neg), .out_parity(out_parity), .flag_z(flag_z), .flag_n(flag_n));
  zero_flag_pipe #(.WIDTH(37), .FANIN(8)) dut37 (
    .clk(clk), .reset_n(reset_n), .in_valid(b_valid), .in_ready(b_in_ready), .in_data(b_data),
    .in_setflags(b_tag), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_zero(b_zero), .out_neg(b_neg), .out_parity(b_parity), .flag_z(b_fz), .flag_n(b_fn));
  int tests = 0;
  int fails = 0;
  logic m_v [L];
  logic [63:0] m_d [L];
  logic m_t [L];
  logic mz, mn;
  function automatic logic par(input logic [63:0] d);
`ifdef ZCHK_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic mreset();
    for (int k = 0; k < L; k++) m_v[k] = 1'b0;
    mz = 1'b0;
    mn = 1'b0;
  endtask
  task automatic check_out();
    logic v;
    logic [63:0] d;
    v = m_v[L-1];
    d = m_d[L-1];
    chk("out_valid", out_valid, v);
    chk("out_zero", out_zero, v && d == 64'd0);
    chk("out_neg", out_neg, v && d[63]);
    chk("out_parity", out_parity, v && par(d));
    chk("flag_z", flag_z, mz);
    chk("flag_n", flag_n, mn);
  endtask
  task automatic cycle(input logic v, input logic [63:0] d, input logic t, input logic f, input logic r);
    logic adv;
    in_valid = v;
    in_data = d;
    in_setflags = t;
    flush = f;
    out_ready = r;
    #1;
    adv = !m_v[L-1] || r;
    chk("in_ready", in_ready, adv && !f);
    @(posedge clk);
    if (m_v[L-1] && r && m_t[L-1]) begin
      mz = m_d[L-1] == 64'd0;
      mn = m_d[L-1][63];
    end
    if (adv) begin
      for (int k = L - 1; k > 0; k--) begin
        m_v[k] = m_v[k-1];
        m_d[k] = m_d[k-1];
        m_t[k] = m_t[k-1];
      end
      m_v[0] = v && !f;
      m_d[0] = d;
      m_t[0] = t;
    end
    if (f) for (int k = 0; k < L; k++) m_v[k] = 1'b0;
    #1;
    check_out();
  endtask
  task automatic rand_cycles(input int n);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0: d = 64'd0;
        1: d = 64'h8000_0000_0000_0000;
        2: d = {$urandom, $urandom};
        default: d = 64'd1 << $urandom_range(0, 63);
      endcase
      cycle($urandom_range(0, 3) != 0, d, 1'($urandom_range(0, 1)),
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end
  endtask
  initial begin
    in_valid = 0; in_data = '0; in_setflags = 0; flush = 0; out_ready = 0;
    b_valid = 0; b_data = '0; b_tag = 1; b_flush = 0; b_out_ready = 1;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    check_out();
    chk("reset_in_ready", in_ready, 1);
    chk("b_reset_valid", b_out_valid, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1, 64'd0, 1, 0, 1);
    cycle(1, 64'h8000_0000_0000_0000, 1, 0, 1);
    cycle(0, 64'd0, 0, 0, 1);
    chk("first_zero", out_zero, 1);
    chk("first_neg", out_neg, 0);
    cycle(0, 64'd0, 0, 0, 1);
    chk("second_zero", out_zero, 0);
    chk("second_neg", out_neg, 1);
    repeat (2) cycle(0, 64'd0, 0, 0, 1);
    chk("flags_end_z", flag_z, 0);
    chk("flags_end_n", flag_n, 1);
    for (int b = 0; b < 64; b++) begin
      cycle(1, 64'd1 << b, 0, 0, 1);
      if (b >= L - 1) begin
        chk("walk_zero", out_zero, 0);
        chk("walk_parity", out_parity, par(64'd1));
      end
    end
    repeat (L) cycle(0, 64'd0, 0, 0, 1);
    cycle(1, 64'h0, 1, 0, 1);
    cycle(1, 64'h8000_0000_0000_0001, 0, 0, 1);
    cycle(1, 64'h0000_0000_0001_0000, 1, 0, 1);
    repeat (5) begin
      cycle(1, 64'hFFFF, 1, 0, 0);
      chk("stall_zero", out_zero, 1);
    end
    repeat (L + 1) cycle(0, 64'd0, 0, 0, 1);
    repeat (3) cycle(1, 64'd0, 1, 0, 1);
    cycle(1, 64'h8000_0000_0000_0000, 1, 1, 0);
    chk("flush_valid", out_valid, 0);
    repeat (L) cycle(0, 64'd0, 0, 0, 1);
    repeat (3) cycle(1, 64'h8000_0000_0000_0000, 1, 0, 1);
    cycle(1, 64'd0, 1, 1, 1);
    repeat (L) cycle(0, 64'd0, 0, 0, 1);
    b_valid = 1; b_data = 37'h1 << 36;
    cycle(0, 64'd0, 0, 0, 1);
    chk("b37_lat1_valid", b_out_valid, 0);
    b_data = 37'd0;
    cycle(0, 64'd0, 0, 0, 1);
    chk("b37_valid", b_out_valid, 1);
    chk("b37_zero", b_zero, 0);
    chk("b37_neg", b_neg, 1);
    chk("b37_parity", b_parity, par(64'd1));
    b_valid = 0;
    cycle(0, 64'd0, 0, 0, 1);
    chk("b37_zero2", b_zero, 1);
    chk("b37_neg2", b_neg, 0);
    chk("b37_fz", b_fz, 0);
    chk("b37_fn", b_fn, 1);
    chk("b37_ready", b_in_ready, 1);
    cycle(0, 64'd0, 0, 0, 1);
    chk("b37_valid_end", b_out_valid, 0);
    chk("b37_fz2", b_fz, 1);
    chk("b37_fn2", b_fn, 0);
    rand_cycles(400);
    repeat (L) cycle(1, 64'd0, 1, 0, 1);
    cycle(1, 64'h1234, 0, 0, 1);
    cycle(1, 64'h8000_0000_0000_0000, 1, 0, 1);
    chk("pre_reset_fz", flag_z, 1);
    reset_n = 1'b0;
    #1;
    mreset();
    check_out();
    chk("async_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_out();
    reset_n = 1'b1;
    rand_cycles(200);
    repeat (L + 1) cycle(0, 64'd0, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
